// File: rtl/spi_flash_responder.sv
// SPI mode-0 slave emulating the read path of a serial NOR flash.
// Decodes a command byte, takes a 24-bit address for READ, then streams bytes from a 1-clk memory.
module spi_flash_responder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  READ_CMD    = 8'h03,
  parameter logic [7:0]  WAKE_CMD    = 8'hAB
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        spi_sck,
  input  logic        spi_ss,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        mem_rd,
  output logic [23:0] mem_addr,
  input  logic [7:0]  mem_data,
  output logic        cmd_strobe,
  output logic [7:0]  cmd_byte,
  output logic        rd_active
);

  typedef enum logic [2:0] {StIdle, StCmd, StAddr, StFetch, StData, StIgnore} state_e;

  logic [SYNC_STAGES-1:0] sck_sync, ss_sync, mosi_sync;
  logic                   sck_prev;
  logic                   sck_s, ss_s, mosi_s, sck_rise, sck_fall;

  // SS chain resets to "selected" so a frame already in progress at reset cannot arm the decoder.
  always_ff @(posedge clk) begin
    if (reset) begin
      sck_sync  <= '0;
      ss_sync   <= '0;
      mosi_sync <= '0;
      sck_prev  <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi_ss};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sck_prev  <= sck_s;
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign ss_s     = ss_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev;
  assign sck_fall = ~sck_s & sck_prev;

  state_e      state_q;
  logic [4:0]  bit_cnt_q;
  logic [22:0] in_sr_q;
  logic [6:0]  tx_sr_q;
  logic [7:0]  prefetch_q;
  logic        fetch_pend_q;
  logic        armed_q;
  logic [7:0]  rx_byte;

  assign rx_byte = {in_sr_q[6:0], mosi_s};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      bit_cnt_q    <= '0;
      in_sr_q      <= '0;
      tx_sr_q      <= '0;
      prefetch_q   <= '0;
      fetch_pend_q <= 1'b0;
      armed_q      <= 1'b0;
      spi_miso     <= 1'b0;
      mem_rd       <= 1'b0;
      mem_addr     <= '0;
      cmd_strobe   <= 1'b0;
      cmd_byte     <= '0;
      rd_active    <= 1'b0;
    end else begin
      cmd_strobe   <= 1'b0;
      mem_rd       <= 1'b0;
      fetch_pend_q <= mem_rd;
      if (fetch_pend_q) prefetch_q <= mem_data;

      if (ss_s) begin
        state_q   <= StIdle;
        bit_cnt_q <= '0;
        spi_miso  <= 1'b0;
        rd_active <= 1'b0;
        armed_q   <= 1'b1;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (armed_q) begin
              state_q   <= StCmd;
              bit_cnt_q <= '0;
            end
          end
          StCmd: begin
            if (sck_rise) begin
              in_sr_q   <= {in_sr_q[21:0], mosi_s};
              bit_cnt_q <= bit_cnt_q + 5'd1;
              if (bit_cnt_q == 5'd7) begin
                cmd_strobe <= 1'b1;
                cmd_byte   <= rx_byte;
                bit_cnt_q  <= '0;
                case (rx_byte)
                  READ_CMD: state_q <= StAddr;
                  WAKE_CMD: state_q <= StIgnore;
                  default:  state_q <= StIgnore;
                endcase
              end
            end
          end
          StAddr: begin
            if (sck_rise) begin
              in_sr_q   <= {in_sr_q[21:0], mosi_s};
              bit_cnt_q <= bit_cnt_q + 5'd1;
              if (bit_cnt_q == 5'd23) begin
                mem_rd    <= 1'b1;
                mem_addr  <= {in_sr_q, mosi_s};
                bit_cnt_q <= '0;
                state_q   <= StFetch;
              end
            end
          end
          StFetch: begin
            // prefetch_q captures mem_data on this same edge
            if (fetch_pend_q) begin
              state_q   <= StData;
              rd_active <= 1'b1;
            end
          end
          StData: begin
            if (sck_fall) begin
              if (bit_cnt_q[2:0] == 3'd0) begin
                tx_sr_q  <= prefetch_q[6:0];
                spi_miso <= prefetch_q[7];
                mem_rd   <= 1'b1;
                mem_addr <= mem_addr + 24'd1;
              end else begin
                tx_sr_q  <= {tx_sr_q[5:0], 1'b0};
                spi_miso <= tx_sr_q[6];
              end
              bit_cnt_q <= {2'b00, bit_cnt_q[2:0] + 3'd1};
            end
          end
          StIgnore: spi_miso <= 1'b0;
          default:  state_q  <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Scoreboard bench for spi_flash_responder: a bit-banged SPI master drives frames, monitors
// compare mem_rd addresses, command strobes and received MISO bytes against queued expectations.
module tb_spi_flash_responder;
  localparam int HALF = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        spi_sck, spi_ss, spi_mosi;
  logic        spi_miso, mem_rd, cmd_strobe, rd_active;
  logic [23:0] mem_addr;
  logic [7:0]  mem_data, cmd_byte;

  int checks = 0;
  int passes = 0;

  logic [7:0]  tx_q[$];
  logic [7:0]  rx_q[$];
  logic [7:0]  exp_rx[$];
  logic [7:0]  exp_cmd[$];
  logic [23:0] exp_rd[$];

  always #5 clk = ~clk;

  spi_flash_responder dut (
    .clk        (clk),
    .reset      (reset),
    .spi_sck    (spi_sck),
    .spi_ss     (spi_ss),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .cmd_strobe (cmd_strobe),
    .cmd_byte   (cmd_byte),
    .rd_active  (rd_active)
  );

  function automatic logic [7:0] mem_val(input logic [23:0] a);
    case (a)
      24'h000100: return 8'h11;
      24'h000101: return 8'h22;
      24'h000102: return 8'h33;
      24'h000103: return 8'h44;
      default:    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h3C;
    endcase
  endfunction

  always @(posedge clk) if (mem_rd) mem_data <= mem_val(mem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitors
  always @(negedge clk) begin
    if (mem_rd) begin
      if (exp_rd.size() == 0) begin
        checks++;
        $display("FAIL rd_unexpected: got mem_rd at %h expected none", mem_addr);
      end else check("rd_addr", {8'h0, mem_addr}, {8'h0, exp_rd.pop_front()});
    end
    if (cmd_strobe) begin
      if (exp_cmd.size() == 0) begin
        checks++;
        $display("FAIL cmd_unexpected: got strobe byte %h expected none", cmd_byte);
      end else check("cmd_byte", {24'h0, cmd_byte}, {24'h0, exp_cmd.pop_front()});
    end
  end

  always @(posedge clk) begin
    while (rx_q.size() > 0) begin
      logic [7:0] got;
      got = rx_q.pop_front();
      if (exp_rx.size() == 0) begin
        checks++;
        $display("FAIL miso_unexpected: got byte %h expected none", got);
      end else check("miso_byte", {24'h0, got}, {24'h0, exp_rx.pop_front()});
    end
  end

  // One SCK period; leaves SCK high. Returns MISO as the master samples it on the rising edge.
  task automatic send_bit(input logic b, output logic r);
    spi_mosi = b;
    repeat (HALF) @(negedge clk);
    r = spi_miso;
    spi_sck = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic frame(input int nbits, input bit hold_ss);
    logic       r;
    logic [7:0] acc;
    logic [7:0] cur;
    acc = '0;
    spi_ss = 1'b0;
    repeat (2 * HALF) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      cur = tx_q[i / 8];
      send_bit(cur[7 - (i % 8)], r);
      acc = {acc[6:0], r};
      if (i % 8 == 7) rx_q.push_back(acc);
      if (i != nbits - 1 || hold_ss) spi_sck = 1'b0;
    end
    // Final SCK fall coincides with SS rising
    if (!hold_ss) begin
      spi_sck = 1'b0;
      spi_ss  = 1'b1;
      repeat (4 * HALF) @(negedge clk);
    end
    tx_q.delete();
  endtask

  task automatic drained(input string name);
    repeat (20) @(negedge clk);
    check({name, "_rd_left"}, exp_rd.size(), 0);
    check({name, "_cmd_left"}, exp_cmd.size(), 0);
    check({name, "_rx_left"}, exp_rx.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic r;
    reset = 1'b1; spi_ss = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_miso", spi_miso, 0);
    check("rst_mem_rd", mem_rd, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_cmd_strobe", cmd_strobe, 0);
    check("rst_cmd_byte", cmd_byte, 0);
    check("rst_rd_active", rd_active, 0);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    // READ 0x000100, four data bytes
    tx_q = '{8'h03, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    exp_cmd.push_back(8'h03);
    exp_rd = '{24'h000100, 24'h000101, 24'h000102, 24'h000103, 24'h000104};
    exp_rx = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    frame(64, 1'b0);
    drained("read100");

    // READ across the top of the address space
    tx_q = '{8'h03, 8'hFF, 8'hFF, 8'hFE, 8'h00, 8'h00, 8'h00};
    exp_cmd.push_back(8'h03);
    exp_rd = '{24'hFFFFFE, 24'hFFFFFF, 24'h000000, 24'h000001};
    exp_rx = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hC2, 8'hC3, 8'h3C};
    frame(56, 1'b0);
    drained("wrap");

    // Wake command, then READ 0
    tx_q = '{8'hAB};
    exp_cmd.push_back(8'hAB);
    exp_rx = '{8'h00};
    frame(8, 1'b0);
    tx_q = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h00};
    exp_cmd.push_back(8'h03);
    exp_rd = '{24'h000000, 24'h000001};
    exp_rx = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h3C};
    frame(40, 1'b0);
    drained("wake");

    // Reset-enable / reset pair inside one frame
    tx_q = '{8'h66, 8'h99, 8'hFF, 8'hA5, 8'h5A, 8'h03, 8'h00, 8'hFF};
    exp_cmd.push_back(8'h66);
    exp_rx = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    frame(64, 1'b0);
    drained("rst66");

    // SS raised mid-address, then READ 0x000010
    tx_q = '{8'h03, 8'h00, 8'h00};
    exp_cmd.push_back(8'h03);
    exp_rx = '{8'h00, 8'h00};
    frame(20, 1'b0);
    tx_q = '{8'h03, 8'h00, 8'h00, 8'h10, 8'h00};
    exp_cmd.push_back(8'h03);
    exp_rd = '{24'h000010, 24'h000011};
    exp_rx = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h2C};
    frame(40, 1'b0);
    drained("abort");

    // Reset mid data byte: 3 data bits of 0x3C shifted, MISO now holds bit4 = 1
    tx_q = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h00};
    exp_cmd.push_back(8'h03);
    exp_rd = '{24'h000000, 24'h000001};
    exp_rx = '{8'h00, 8'h00, 8'h00, 8'h00};
    frame(35, 1'b1);
    repeat (6) @(negedge clk);
    check("mid_rd_active", rd_active, 1);
    check("mid_miso", spi_miso, 1);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_miso", spi_miso, 0);
    check("rst_mid_rd_active", rd_active, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    // Still inside the old frame: a READ byte here must not be decoded
    for (int i = 7; i >= 0; i--) begin
      send_bit(i < 2, r);
      spi_sck = 1'b0;
    end
    repeat (10) @(negedge clk);
    check("post_rst_miso", spi_miso, 0);
    spi_ss = 1'b1;
    repeat (10) @(negedge clk);
    tx_q = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h00};
    exp_cmd.push_back(8'h03);
    exp_rd = '{24'h000000, 24'h000001};
    exp_rx = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h3C};
    frame(40, 1'b0);
    drained("reset");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
